tof_frame_reader: RTL and testbench

Reads one complete ToF frame out of the ToF data BRAM through its read port (port B) once the BRAM write controller reports that all sensors have been stored. It walks all 512 locations (8 sensors × 64 zones) in address order and emits them as a valid/ready stream tagged with sensor index, zone index and end-of-frame. It sits between the frame-complete strobe and any downstream consumer, such as the host link or the surface calculators. Back-pressure is absorbed by a small credit-controlled buffer, so BRAM read latency never loses data.

---
 rtl/tof_pkg.sv | 25 ++
 rtl/tof_frame_reader_if.sv | 15 +
 rtl/tof_rd_fifo.sv | 61 ++++++
 rtl/tof_frame_reader.sv | 145 ++++++++++++++
 tb/tb_tof_frame_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tof_pkg.sv
// Shared constants and types for the ToF frame read path.
// BRAM address layout is {sensor, zone}; buffer entries carry the address as a tag.
package tof_pkg;

  localparam int TOF_SENSORS = 8;
  localparam int TOF_ZONES   = 64;
  localparam int TOF_SENS_W  = 3;
  localparam int TOF_ZONE_W  = 6;
  localparam int TOF_ADDR_W  = 9;
  localparam int TOF_DATA_W  = 16;

  localparam logic [TOF_ADDR_W-1:0] TOF_LAST_ADDR = TOF_ADDR_W'(TOF_SENSORS * TOF_ZONES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [TOF_ADDR_W-1:0] addr;
    logic [TOF_DATA_W-1:0] data;
  } tof_entry_t;

endpackage

// File: rtl/tof_frame_reader_if.sv
// Valid/ready stream of tagged ToF distance words.
interface tof_frame_reader_if;
  import tof_pkg::*;

  logic                  m_valid;
  logic                  m_ready;
  logic [TOF_DATA_W-1:0] m_data;
  logic [TOF_SENS_W-1:0] m_sensor;
  logic [TOF_ZONE_W-1:0] m_zone;
  logic                  m_last;

  modport master (output m_valid, m_data, m_sensor, m_zone, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_sensor, m_zone, m_last, output m_ready);

endinterface

// File: rtl/tof_rd_fifo.sv
// Show-ahead FIFO for returned BRAM words; head reads as zero while empty so the
// stream outputs sit at zero whenever no word is offered.
module tof_rd_fifo
  import tof_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  tof_entry_t       push_entry,
  input  logic             pop,
  output logic             empty,
  output tof_entry_t       head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  tof_entry_t       mem_q [DEPTH];
  tof_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/tof_frame_reader.sv
// Streams one ToF frame (8 sensors x 64 zones) out of BRAM port B on start.
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads while credits allow
// FLUSH | all reads issued, draining in-flight reads and buffer
module tof_frame_reader
  import tof_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  enb,
  output logic [TOF_ADDR_W-1:0] addrb,
  input  logic [TOF_DATA_W-1:0] doutb,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  tof_frame_reader_if.master    strm
);

  localparam int         DEPTH   = RD_LAT + 2;
  localparam int         CNT_W   = $clog2(DEPTH + 1);
  localparam logic [3:0] CREDITS = 4'(DEPTH);

  rd_state_e             state_q, state_d;
  logic [TOF_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TOF_ADDR_W-1:0] addrb_q, addrb_d;
  logic                  overrun_q, overrun_d;
  logic                  done_q, done_d;
  logic [RD_LAT-1:0]     v_pipe_q, v_pipe_d;
  logic [TOF_ADDR_W-1:0] a_pipe_q [RD_LAT];
  logic [TOF_ADDR_W-1:0] a_pipe_d [RD_LAT];
  logic [3:0]            in_flight;
  logic [CNT_W-1:0]      buf_count;
  logic                  issue, fifo_empty, pop, credit_ok;
  tof_entry_t            push_entry, head;

  // Reads still travelling through the BRAM pipeline hold a credit until pushed.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + 4'(v_pipe_q[i]);
    end
  end

  assign credit_ok = (4'(buf_count) + in_flight) < CREDITS;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          rd_ptr_d  = '0;
          overrun_d = 1'b0;
        end
      end
      RUN: begin
        if (start) overrun_d = 1'b1;
        if (credit_ok) begin
          issue = 1'b1;
          if (rd_ptr_q == TOF_LAST_ADDR) state_d = FLUSH;
          else rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      FLUSH: begin
        if (start) overrun_d = 1'b1;
        if (pop && (head.addr == TOF_LAST_ADDR)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enb     = issue;
  assign addrb   = issue ? rd_ptr_q : addrb_q;
  assign addrb_d = addrb;

  always_comb begin
    v_pipe_d    = v_pipe_q;
    a_pipe_d    = a_pipe_q;
    v_pipe_d[0] = issue;
    a_pipe_d[0] = rd_ptr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      v_pipe_d[i] = v_pipe_q[i-1];
      a_pipe_d[i] = a_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      addrb_q   <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      v_pipe_q  <= '0;
      a_pipe_q  <= '{default: '0};
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      addrb_q   <= addrb_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      v_pipe_q  <= v_pipe_d;
      a_pipe_q  <= a_pipe_d;
    end
  end

  assign push_entry = '{addr: a_pipe_q[RD_LAT-1], data: doutb};
  assign pop        = !fifo_empty && strm.m_ready;

  tof_rd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (v_pipe_q[RD_LAT-1]),
    .push_entry (push_entry),
    .pop        (pop),
    .empty      (fifo_empty),
    .head       (head),
    .count      (buf_count)
  );

  assign strm.m_valid  = !fifo_empty;
  assign strm.m_data   = head.data;
  assign strm.m_sensor = head.addr[TOF_ADDR_W-1 -: TOF_SENS_W];
  assign strm.m_zone   = head.addr[TOF_ZONE_W-1:0];
  assign strm.m_last   = (head.addr == TOF_LAST_ADDR);

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tof_frame_reader.sv
// Bench for tof_frame_reader: RD_LAT=1 instance for most scenarios, RD_LAT=2 for back-to-back.
module tb_tof_frame_reader;
  import tof_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // RD_LAT = 1 instance
  logic        start1 = 1'b0, enb1, busy1, done1, overrun1;
  logic [8:0]  addrb1;
  logic [15:0] doutb1 = '0, key1 = '0;
  tof_frame_reader_if s1();
  tof_frame_reader #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .enb(enb1), .addrb(addrb1),
    .doutb(doutb1), .busy(busy1), .done(done1), .overrun(overrun1), .strm(s1));

  // RD_LAT = 2 instance
  logic        start2 = 1'b0, enb2, busy2, done2, overrun2;
  logic [8:0]  addrb2;
  logic [15:0] doutb2 = '0, key2 = '0, bram2_s1 = '0;
  tof_frame_reader_if s2();
  tof_frame_reader #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .enb(enb2), .addrb(addrb2),
    .doutb(doutb2), .busy(busy2), .done(done2), .overrun(overrun2), .strm(s2));

  // BRAM models: content is addr ^ key
  always @(posedge clk) if (enb1) doutb1 <= 16'(addrb1) ^ key1;
  always @(posedge clk) begin
    if (enb2) bram2_s1 <= 16'(addrb2) ^ key2;
    doutb2 <= bram2_s1;
  end

  // Reference: word k of a frame is {last, sensor, zone, data}
  function automatic logic [25:0] model_word(int k, logic [15:0] key);
    return {(k == 511), 3'(k / 64), 6'(k % 64), 16'(k) ^ key};
  endfunction

  logic [25:0] rx1[$], rx2[$];
  logic [25:0] mon_w1, prev1;
  int iss1 = 0, pop1 = 0, max_out1 = 0, stab_err1 = 0;
  int first_v1 = -1, last_hs1 = -1, done_cnt1 = 0, done_cyc1 = -1;
  int first_v2 = -1;
  bit stall1 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      iss1 = 0; pop1 = 0; stall1 = 0;
    end else begin
      mon_w1 = {s1.m_last, s1.m_sensor, s1.m_zone, s1.m_data};
      if (iss1 + int'(enb1) - pop1 > max_out1) max_out1 = iss1 + int'(enb1) - pop1;
      if (enb1) iss1++;
      if (stall1 && (!s1.m_valid || mon_w1 !== prev1)) stab_err1++;
      stall1 = s1.m_valid && !s1.m_ready;
      prev1  = mon_w1;
      if (s1.m_valid && first_v1 < 0) first_v1 = cyc;
      if (s1.m_valid && s1.m_ready) begin
        rx1.push_back(mon_w1);
        pop1++;
        if (s1.m_last) last_hs1 = cyc;
      end
      if (done1) begin done_cnt1++; done_cyc1 = cyc; end
      if (s2.m_valid && first_v2 < 0) first_v2 = cyc;
      if (s2.m_valid && s2.m_ready) rx2.push_back({s2.m_last, s2.m_sensor, s2.m_zone, s2.m_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame1(input logic [15:0] key, output int t0);
    rx1.delete();
    first_v1 = -1; last_hs1 = -1; done_cnt1 = 0; done_cyc1 = -1;
    key1 = key;
    start1 = 1'b1;
    t0 = cyc;
    tick();
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s1.m_ready = 1'b0;
    s2.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s1.m_valid, enb1, busy1, done1, overrun1, s1.m_last} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl1: got %b want 000000", {s1.m_valid, enb1, busy1, done1, overrun1, s1.m_last});
    end
    checks++;
    if (addrb1 !== 9'd0) begin errors++; $display("FAIL reset_addrb1: got %0d want 0", addrb1); end
    checks++;
    if ({s1.m_sensor, s1.m_zone, s1.m_data} !== 25'd0) begin
      errors++; $display("FAIL reset_data1: got %h want 0", {s1.m_sensor, s1.m_zone, s1.m_data});
    end
    checks++;
    if ({s2.m_valid, enb2, busy2, done2, overrun2, addrb2, s2.m_data} !== '0) begin
      errors++; $display("FAIL reset_dut2: got %h want 0", {s2.m_valid, enb2, busy2, done2, overrun2, addrb2, s2.m_data});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy1, enb1, s1.m_valid} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b want 000", {busy1, enb1, s1.m_valid});
    end
  endtask

  task automatic test_full_rate();
    int t0;
    s1.m_ready = 1'b1;
    begin_frame1(16'hA5A5, t0);
    checks++;
    if ({enb1, addrb1} !== {1'b1, 9'd0}) begin
      errors++; $display("FAIL full_first_read: got enb=%b addrb=%0d want enb=1 addrb=0", enb1, addrb1);
    end
    for (int i = 0; i < 1000 && done_cnt1 == 0; i++) tick();
    repeat (3) tick();
    checks++;
    if (rx1.size() != 512) begin errors++; $display("FAIL full_count: got %0d want 512", rx1.size()); end
    for (int k = 0; k < rx1.size() && k < 512; k++) begin
      checks++;
      if (rx1[k] !== model_word(k, 16'hA5A5)) begin
        errors++; $display("FAIL full_word[%0d]: got %h want %h", k, rx1[k], model_word(k, 16'hA5A5));
      end
    end
    checks++;
    if (first_v1 != t0 + 3) begin errors++; $display("FAIL full_first_valid: got %0d want %0d", first_v1 - t0, 3); end
    checks++;
    if (last_hs1 != t0 + 514) begin errors++; $display("FAIL full_last_hs: got %0d want %0d", last_hs1 - t0, 514); end
    checks++;
    if (done_cyc1 != t0 + 515) begin errors++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc1 - t0, 515); end
    checks++;
    if (done_cnt1 != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt1); end
    checks++;
    if ({busy1, overrun1} !== 2'b00) begin errors++; $display("FAIL full_end_state: got %b want 00", {busy1, overrun1}); end
  endtask

  task automatic test_stall();
    int t0;
    max_out1 = 0; stab_err1 = 0;
    s1.m_ready = 1'b0;
    begin_frame1(16'h1234, t0);
    for (int i = 0; i < 5000 && done_cnt1 == 0; i++) begin
      s1.m_ready = ($urandom_range(0, 99) >= 30);
      tick();
    end
    s1.m_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (rx1.size() != 512) begin errors++; $display("FAIL stall_count: got %0d want 512", rx1.size()); end
    for (int k = 0; k < rx1.size() && k < 512; k++) begin
      checks++;
      if (rx1[k] !== model_word(k, 16'h1234)) begin
        errors++; $display("FAIL stall_word[%0d]: got %h want %h", k, rx1[k], model_word(k, 16'h1234));
      end
    end
    checks++;
    if (max_out1 > 3) begin errors++; $display("FAIL stall_occupancy: got %0d want <=3", max_out1); end
    checks++;
    if (stab_err1 != 0) begin errors++; $display("FAIL stall_stability: got %0d unstable cycles want 0", stab_err1); end
    checks++;
    if (done_cnt1 != 1) begin errors++; $display("FAIL stall_done_count: got %0d want 1", done_cnt1); end
  endtask

  task automatic test_hold_low();
    int t0, snap;
    s1.m_ready = 1'b1;
    begin_frame1(16'h0F0F, t0);
    for (int i = 0; i < 20 && rx1.size() == 0; i++) tick();
    s1.m_ready = 1'b0;
    repeat (10) tick();
    snap = iss1;
    repeat (90) tick();
    checks++;
    if (iss1 != snap) begin errors++; $display("FAIL hold_no_reads: got %0d extra reads want 0", iss1 - snap); end
    checks++;
    if (iss1 - pop1 != 3) begin errors++; $display("FAIL hold_outstanding: got %0d want 3", iss1 - pop1); end
    checks++;
    if ({enb1, s1.m_valid} !== 2'b01) begin errors++; $display("FAIL hold_enb_valid: got %b want 01", {enb1, s1.m_valid}); end
    checks++;
    if (rx1.size() != 1) begin errors++; $display("FAIL hold_rx_count: got %0d want 1", rx1.size()); end
    s1.m_ready = 1'b1;
    for (int i = 0; i < 1000 && done_cnt1 == 0; i++) tick();
    tick();
    checks++;
    if (rx1.size() != 512) begin errors++; $display("FAIL hold_count: got %0d want 512", rx1.size()); end
    for (int k = 0; k < rx1.size() && k < 512; k++) begin
      checks++;
      if (rx1[k] !== model_word(k, 16'h0F0F)) begin
        errors++; $display("FAIL hold_word[%0d]: got %h want %h", k, rx1[k], model_word(k, 16'h0F0F));
      end
    end
  endtask

  task automatic test_overrun();
    int t0;
    s1.m_ready = 1'b1;
    begin_frame1(16'h5A5A, t0);
    repeat (198) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if ({overrun1, busy1} !== 2'b11) begin errors++; $display("FAIL ovr_set: got %b want 11", {overrun1, busy1}); end
    for (int i = 0; i < 1000 && done_cnt1 == 0; i++) tick();
    repeat (2) tick();
    checks++;
    if (rx1.size() != 512) begin errors++; $display("FAIL ovr_count: got %0d want 512", rx1.size()); end
    for (int k = 0; k < rx1.size() && k < 512; k++) begin
      checks++;
      if (rx1[k] !== model_word(k, 16'h5A5A)) begin
        errors++; $display("FAIL ovr_word[%0d]: got %h want %h", k, rx1[k], model_word(k, 16'h5A5A));
      end
    end
    checks++;
    if ({overrun1, busy1, done_cnt1 == 1} !== 3'b101) begin
      errors++; $display("FAIL ovr_after_done: got ovr=%b busy=%b dones=%0d want 1 0 1", overrun1, busy1, done_cnt1);
    end
    begin_frame1(16'h7777, t0);
    checks++;
    if ({overrun1, busy1} !== 2'b01) begin errors++; $display("FAIL ovr_clear: got %b want 01", {overrun1, busy1}); end
    for (int i = 0; i < 1000 && done_cnt1 == 0; i++) tick();
    tick();
    checks++;
    if (rx1.size() != 512) begin errors++; $display("FAIL ovr_second_count: got %0d want 512", rx1.size()); end
  endtask

  task automatic test_reset_mid();
    int t0;
    s1.m_ready = 1'b1;
    begin_frame1(16'h3C3C, t0);
    for (int i = 0; i < 1000 && rx1.size() < 300; i++) tick();
    done_cnt1 = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s1.m_valid, enb1, busy1, done1, overrun1, s1.m_last, addrb1} !== '0) begin
      errors++; $display("FAIL rstmid_ctrl: got %h want 0", {s1.m_valid, enb1, busy1, done1, overrun1, s1.m_last, addrb1});
    end
    checks++;
    if ({s1.m_sensor, s1.m_zone, s1.m_data} !== 25'd0) begin
      errors++; $display("FAIL rstmid_data: got %h want 0", {s1.m_sensor, s1.m_zone, s1.m_data});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if ({done_cnt1 != 0, busy1, s1.m_valid} !== 3'b000) begin
      errors++; $display("FAIL rstmid_no_done: got dones=%0d busy=%b valid=%b want 0 0 0", done_cnt1, busy1, s1.m_valid);
    end
    begin_frame1(16'hC3C3, t0);
    checks++;
    if ({enb1, addrb1} !== {1'b1, 9'd0}) begin
      errors++; $display("FAIL rstmid_restart: got enb=%b addrb=%0d want enb=1 addrb=0", enb1, addrb1);
    end
    for (int i = 0; i < 1000 && done_cnt1 == 0; i++) tick();
    repeat (2) tick();
    checks++;
    if (rx1.size() != 512) begin errors++; $display("FAIL rstmid_count: got %0d want 512", rx1.size()); end
    for (int k = 0; k < rx1.size() && k < 512; k++) begin
      checks++;
      if (rx1[k] !== model_word(k, 16'hC3C3)) begin
        errors++; $display("FAIL rstmid_word[%0d]: got %h want %h", k, rx1[k], model_word(k, 16'hC3C3));
      end
    end
    checks++;
    if (done_cnt1 != 1) begin errors++; $display("FAIL rstmid_done_count: got %0d want 1", done_cnt1); end
  endtask

  task automatic test_back_to_back();
    int t0a, t0b, d;
    logic [15:0] keys [2];
    keys[0] = 16'h1111;
    keys[1] = 16'h2222;
    s2.m_ready = 1'b1;
    rx2.delete();
    first_v2 = -1;
    key2 = keys[0];
    start2 = 1'b1;
    t0a = cyc;
    tick();
    start2 = 1'b0;
    d = -1;
    for (int i = 0; i < 1000 && d < 0; i++) begin
      tick();
      if (done2) d = cyc;
    end
    checks++;
    if (d != t0a + 516) begin errors++; $display("FAIL b2b_doneA_cycle: got %0d want %0d", d - t0a, 516); end
    checks++;
    if (first_v2 != t0a + 4) begin errors++; $display("FAIL b2b_first_validA: got %0d want 4", first_v2 - t0a); end
    checks++;
    if (rx2.size() != 512) begin errors++; $display("FAIL b2b_countA: got %0d want 512", rx2.size()); end
    for (int k = 0; k < rx2.size() && k < 512; k++) begin
      checks++;
      if (rx2[k] !== model_word(k, keys[0])) begin
        errors++; $display("FAIL b2b_wordA[%0d]: got %h want %h", k, rx2[k], model_word(k, keys[0]));
      end
    end
    rx2.delete();
    first_v2 = -1;
    key2 = keys[1];
    start2 = 1'b1;
    t0b = cyc;
    tick();
    start2 = 1'b0;
    checks++;
    if ({busy2, overrun2} !== 2'b10) begin errors++; $display("FAIL b2b_startB: got busy,ovr=%b want 10", {busy2, overrun2}); end
    d = -1;
    for (int i = 0; i < 1000 && d < 0; i++) begin
      tick();
      if (done2) d = cyc;
    end
    checks++;
    if (d != t0b + 516) begin errors++; $display("FAIL b2b_doneB_cycle: got %0d want %0d", d - t0b, 516); end
    checks++;
    if (first_v2 != t0b + 4) begin errors++; $display("FAIL b2b_first_validB: got %0d want 4", first_v2 - t0b); end
    checks++;
    if (rx2.size() != 512) begin errors++; $display("FAIL b2b_countB: got %0d want 512", rx2.size()); end
    for (int k = 0; k < rx2.size() && k < 512; k++) begin
      checks++;
      if (rx2[k] !== model_word(k, keys[1])) begin
        errors++; $display("FAIL b2b_wordB[%0d]: got %h want %h", k, rx2[k], model_word(k, keys[1]));
      end
    end
    checks++;
    if (overrun2 !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun2); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_stall();
    test_hold_low();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
